// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with a
// memory-ready stall. Define ILLEGAL_OPCODE_TRAP_EN to trap on illegal opcodes (adds Trap port).
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  input  logic                Zero,
  output logic                PCWrite,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemToWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegisterWrite,
  output logic                RegDst,
  output logic                Branch,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic [STATE_W-1:0]  State
`ifdef ILLEGAL_OPCODE_TRAP_EN
  ,
  output logic                Trap
`endif
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StRWb     = 4'd3,
    StExecI   = 4'd4,
    StIWb     = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWr   = 4'd8,
    StMemWb   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [OPCODE_W-1:0] OpR    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OpMul  = OPCODE_W'(6'b011100);
  localparam logic [OPCODE_W-1:0] OpLw   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OpSw   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OpBeq  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OpJ    = OPCODE_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] AluAdd   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] AluSub   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] AluFunct = ALUOP_W'(3'b010);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q;

  // Opcode captured in DECODE so MEM_ADDR can split LW/SW after the bus has moved on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) opcode_q <= Opcode;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:   state_d = MemReady ? StDecode : StFetch;
      StDecode: begin
        case (Opcode)
          OpR, OpMul: state_d = StExecR;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StExecI;
          OpJ:        state_d = StJump;
`ifdef ILLEGAL_OPCODE_TRAP_EN
          default:    state_d = StTrap;
`else
          default:    state_d = StFetch;
`endif
        endcase
      end
      StExecR:   state_d = StRWb;
      StExecI:   state_d = StIWb;
      StMemAddr: state_d = (opcode_q == OpLw) ? StMemRd : StMemWr;
      StMemRd:   state_d = MemReady ? StMemWb : StMemRd;
      StMemWr:   state_d = MemReady ? StFetch : StMemWr;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      StTrap:    state_d = StTrap;
`endif
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    PCWrite       = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemToWrite    = 1'b0;
    IRWrite       = 1'b0;
    MemToReg      = 1'b0;
    RegisterWrite = 1'b0;
    RegDst        = 1'b0;
    Branch        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = AluAdd;
    PCSource      = 2'b00;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    Trap          = 1'b0;
`endif
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
        end
      end
      StDecode:  ALUSrcB = 2'b11;
      StExecR: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluFunct;
      end
      StRWb: begin
        RegDst        = 1'b1;
        RegisterWrite = 1'b1;
      end
      StExecI, StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StIWb:     RegisterWrite = 1'b1;
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWr: begin
        MemToWrite = 1'b1;
        IorD       = 1'b1;
      end
      StMemWb: begin
        RegisterWrite = 1'b1;
        MemToReg      = 1'b1;
      end
      StBranch: begin
        ALUSrcA  = 1'b1;
        ALUOp    = AluSub;
        PCSource = 2'b01;
        Branch   = 1'b1;
        PCWrite  = Zero;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      StTrap:    Trap = 1'b1;
`endif
      default: ;
    endcase
  end

  assign State = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboarded bench for multicycle_control_unit: per-instruction reference sequences are
// queued as stimulus is driven; a negedge monitor compares the full output vector each cycle.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       MemReady, Zero;
  logic       PCWrite, IorD, MemRead, MemToWrite, IRWrite, MemToReg, RegisterWrite, RegDst;
  logic       Branch, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic       Trap;
`endif

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .Opcode        (Opcode),
    .MemReady      (MemReady),
    .Zero          (Zero),
    .PCWrite       (PCWrite),
    .IorD          (IorD),
    .MemRead       (MemRead),
    .MemToWrite    (MemToWrite),
    .IRWrite       (IRWrite),
    .MemToReg      (MemToReg),
    .RegisterWrite (RegisterWrite),
    .RegDst        (RegDst),
    .Branch        (Branch),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .PCSource      (PCSource),
    .State         (State)
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    .Trap          (Trap)
`endif
  );

  localparam int FETCH = 0, DECODE = 1, EXEC_R = 2, R_WB = 3, EXEC_I = 4, I_WB = 5;
  localparam int MEM_ADDR = 6, MEM_RD = 7, MEM_WR = 8, MEM_WB = 9, BRANCH = 10, JUMP = 11;
  localparam int TRAP = 12;

  typedef struct packed {
    logic [3:0] state;
    logic       pcwrite, iord, memread, memwrite, irwrite, memtoreg, regwrite, regdst;
    logic       branch, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsource;
    logic       trap;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  vec_t act;

  always_comb begin
    act          = '0;
    act.state    = State;
    act.pcwrite  = PCWrite;
    act.iord     = IorD;
    act.memread  = MemRead;
    act.memwrite = MemToWrite;
    act.irwrite  = IRWrite;
    act.memtoreg = MemToReg;
    act.regwrite = RegisterWrite;
    act.regdst   = RegDst;
    act.branch   = Branch;
    act.alusrca  = ALUSrcA;
    act.alusrcb  = ALUSrcB;
    act.aluop    = ALUOp;
    act.pcsource = PCSource;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    act.trap     = Trap;
`endif
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (act === e.v) n_pass++;
        else $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                      e.tag, act.state, act, e.v.state, e.v);
      end
    end
  end

  function automatic vec_t base(input int st);
    vec_t v;
    v       = '0;
    v.state = 4'(st);
    return v;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b011100, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                      6'b000010};
  endfunction

  // Inputs the current state must ignore get random values.
  task automatic noise();
    Opcode   = 6'($urandom);
    MemReady = 1'($urandom);
    Zero     = 1'($urandom);
  endtask

  task automatic cyc(input vec_t v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int waits);
    vec_t v;
    for (int i = 0; i < waits; i++) begin
      noise();
      MemReady  = 1'b0;
      v         = base(FETCH);
      v.memread = 1'b1;
      cyc(v, "fetch_wait");
    end
    noise();
    MemReady  = 1'b1;
    v         = base(FETCH);
    v.memread = 1'b1;
    v.irwrite = 1'b1;
    v.pcwrite = 1'b1;
    v.alusrcb = 2'b01;
    cyc(v, "fetch");
  endtask

  task automatic do_decode(input logic [5:0] op);
    vec_t v;
    noise();
    Opcode    = op;
    v         = base(DECODE);
    v.alusrcb = 2'b11;
    cyc(v, "decode");
  endtask

  task automatic do_mem_addr();
    vec_t v;
    noise();
    v         = base(MEM_ADDR);
    v.alusrca = 1'b1;
    v.alusrcb = 2'b10;
    cyc(v, "mem_addr");
  endtask

  task automatic do_mem(input int st, input int waits);
    vec_t v;
    v      = base(st);
    v.iord = 1'b1;
    if (st == MEM_RD) v.memread = 1'b1;
    else v.memwrite = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      noise();
      MemReady = (i == waits);
      cyc(v, (st == MEM_RD) ? "mem_rd" : "mem_wr");
    end
  endtask

  task automatic issue(input logic [5:0] op, input int fw, input int mw, input bit z);
    vec_t v;
    do_fetch(fw);
    do_decode(op);
    case (op)
      6'b000000, 6'b011100: begin
        noise();
        v = base(EXEC_R);
        v.alusrca = 1'b1;
        v.aluop   = 3'b010;
        cyc(v, "exec_r");
        noise();
        v = base(R_WB);
        v.regdst   = 1'b1;
        v.regwrite = 1'b1;
        cyc(v, "r_wb");
      end
      6'b100011: begin
        do_mem_addr();
        do_mem(MEM_RD, mw);
        noise();
        v = base(MEM_WB);
        v.memtoreg = 1'b1;
        v.regwrite = 1'b1;
        cyc(v, "mem_wb");
      end
      6'b101011: begin
        do_mem_addr();
        do_mem(MEM_WR, mw);
      end
      6'b000100: begin
        noise();
        Zero = z;
        v = base(BRANCH);
        v.alusrca  = 1'b1;
        v.aluop    = 3'b001;
        v.pcsource = 2'b01;
        v.branch   = 1'b1;
        v.pcwrite  = z;
        cyc(v, z ? "branch_taken" : "branch_not_taken");
      end
      6'b001000: begin
        noise();
        v = base(EXEC_I);
        v.alusrca = 1'b1;
        v.alusrcb = 2'b10;
        cyc(v, "exec_i");
        noise();
        v = base(I_WB);
        v.regwrite = 1'b1;
        cyc(v, "i_wb");
      end
      6'b000010: begin
        noise();
        v = base(JUMP);
        v.pcwrite  = 1'b1;
        v.pcsource = 2'b10;
        cyc(v, "jump");
      end
      default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
        v = base(TRAP);
        v.trap = 1'b1;
        for (int i = 0; i < 3; i++) begin
          noise();
          cyc(v, "trap_hold");
        end
        noise();
        reset = 1'b1;
        cyc(v, "trap_reset");
        reset = 1'b0;
`endif
      end
    endcase
  endtask

  logic [5:0] legal[7] = '{6'b000000, 6'b011100, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                           6'b000010};

  initial begin : stim
    vec_t       v;
    logic [5:0] op;
    reset    = 1'b1;
    MemReady = 1'b1;
    Opcode   = '0;
    Zero     = 1'b0;
    @(posedge clk);
    #1;
    v         = base(FETCH);
    v.memread = 1'b1;
    v.irwrite = 1'b1;
    v.pcwrite = 1'b1;
    v.alusrcb = 2'b01;
    cyc(v, "reset");
    reset = 1'b0;

    issue(6'b000000, 0, 0, 1'b0);
    issue(6'b100011, 0, 3, 1'b0);
    issue(6'b000100, 0, 0, 1'b1);
    issue(6'b000100, 1, 0, 1'b0);
    issue(6'b101011, 2, 1, 1'b0);
    issue(6'b001000, 0, 0, 1'b0);
    issue(6'b000010, 0, 0, 1'b0);
    issue(6'b011100, 1, 0, 1'b0);
    issue(6'b111111, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal[$urandom_range(6)];
      end
      issue(op, $urandom_range(2), $urandom_range(2), 1'($urandom));
    end

    // Reset while SW is stalled in MEM_WR.
    do_fetch(0);
    do_decode(6'b101011);
    do_mem_addr();
    noise();
    MemReady   = 1'b0;
    reset      = 1'b1;
    v          = base(MEM_WR);
    v.iord     = 1'b1;
    v.memwrite = 1'b1;
    cyc(v, "mem_wr_reset");
    reset     = 1'b0;
    noise();
    MemReady  = 1'b0;
    v         = base(FETCH);
    v.memread = 1'b1;
    cyc(v, "after_reset");
    issue(6'b000000, 0, 0, 1'b0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
